axi4_test_sequencer: RTL and testbench

//  Runs the AXI4 memory test engines as a repeated write-then-read-verify loop

---
 rtl/axi4_test_pkg.sv | 18 +
 rtl/axi4_test_sequencer_sat_counter.sv | 39 +++
 rtl/axi4_test_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_axi4_test_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_test_pkg.sv
// Shared types and defaults for the AXI4 memory-test sequencer.
//  seq_state_t     : sequencer FSM states
//  TMO_CYCLES_DFLT : default per-phase watchdog limit
package axi4_test_pkg;

   localparam int unsigned TMO_CYCLES_DFLT = 32'h000F_FFFF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_GO   = 3'd1,
      WR_WAIT = 3'd2,
      RD_GO   = 3'd3,
      RD_WAIT = 3'd4,
      CHECK   = 3'd5,
      FIN     = 3'd6
   } seq_state_t;

endpackage

// File: rtl/axi4_test_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//  clk, reset : clock, asynchronous active-high reset
//  clr_i      : synchronous clear (wins over inc_i)
//  inc_i      : add one unless already saturated
//  count_o    : registered count
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear, saturating increment, or hold
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/axi4_test_sequencer.sv
// Runs the AXI4 write/read-verify test engines as a repeated loop from a
// single run command, counting passing/failing iterations and guarding each
// engine phase with a watchdog.
//  clk, reset          : clock, asynchronous active-high reset
//  run, stop           : start a sequence / end after the current iteration
//  iterations          : iteration count latched on run (0 = until stop)
//  busy, finished      : sequence active / 1-cycle end pulse
//  timeout             : sticky, last sequence aborted on watchdog expiry
//  pass_count          : iterations with no engine error
//  fail_count          : iterations with an engine error or a timeout
//  wr_start/wr_done/wr_error : write engine handshake
//  rd_start/rd_done/rd_error : read/verify engine handshake
module axi4_test_sequencer
   import axi4_test_pkg::*;
#(
   parameter int unsigned ITER_WIDTH = 16,
   parameter int unsigned TMO_WIDTH  = 20,
   parameter int unsigned TMO_CYCLES = TMO_CYCLES_DFLT,
   parameter bit          RD_ENABLE  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  stop,
   input  logic [ITER_WIDTH-1:0] iterations,
   output logic                  busy,
   output logic                  finished,
   output logic                  timeout,
   output logic [ITER_WIDTH-1:0] pass_count,
   output logic [ITER_WIDTH-1:0] fail_count,
   output logic                  wr_start,
   input  logic                  wr_done,
   input  logic                  wr_error,
   output logic                  rd_start,
   input  logic                  rd_done,
   input  logic                  rd_error
);

   localparam int unsigned          IW1      = ITER_WIDTH + 1;
   localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYCLES - 1);

   seq_state_t            state_q, state_d;
   logic [ITER_WIDTH-1:0] iter_lim_q, iter_lim_d;
   logic [TMO_WIDTH-1:0]  wdog_q, wdog_d;
   logic                  stop_pend_q, stop_pend_d;
   logic                  err_q, err_d;
   logic                  timeout_q, timeout_d;
   logic                  busy_q, finished_q, wr_start_q, rd_start_q;

   logic                  cnt_clr;
   logic                  pass_inc;
   logic                  fail_inc;
   logic                  iter_inc;
   logic [ITER_WIDTH-1:0] iter_cnt;
   logic                  last_iter_c;
   logic                  wdog_exp_c;

   // Compare one bit wider so a saturated iter_cnt can never alias a limit
   assign last_iter_c = (iter_lim_q != '0) &&
                        ((IW1'(iter_cnt) + IW1'(1)) == IW1'(iter_lim_q));
   assign wdog_exp_c  = (wdog_q == TMO_LAST);

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      iter_lim_d  = iter_lim_q;
      wdog_d      = wdog_q;
      stop_pend_d = stop_pend_q;
      err_d       = err_q;
      timeout_d   = timeout_q;
      cnt_clr     = 1'b0;
      pass_inc    = 1'b0;
      fail_inc    = 1'b0;
      iter_inc    = 1'b0;

      if ((state_q != IDLE) && stop) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (run) begin
               cnt_clr    = 1'b1;
               timeout_d  = 1'b0;
               err_d      = 1'b0;
               iter_lim_d = iterations;
               state_d    = WR_GO;
            end
         end
         WR_GO: begin
            wdog_d  = '0;
            state_d = WR_WAIT;
         end
         // A done in the expiry cycle takes priority over the timeout
         WR_WAIT: begin
            if (wr_done) begin
               err_d   = err_q | wr_error;
               state_d = RD_ENABLE ? RD_GO : CHECK;
            end else if (wdog_exp_c) begin
               timeout_d = 1'b1;
               fail_inc  = 1'b1;
               state_d   = FIN;
            end else begin
               wdog_d = wdog_q + TMO_WIDTH'(1);
            end
         end
         RD_GO: begin
            wdog_d  = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (rd_done) begin
               err_d   = err_q | rd_error;
               state_d = CHECK;
            end else if (wdog_exp_c) begin
               timeout_d = 1'b1;
               fail_inc  = 1'b1;
               state_d   = FIN;
            end else begin
               wdog_d = wdog_q + TMO_WIDTH'(1);
            end
         end
         // A stop arriving in this very cycle also ends the sequence here
         CHECK: begin
            pass_inc = ~err_q;
            fail_inc = err_q;
            iter_inc = 1'b1;
            err_d    = 1'b0;
            if (stop_pend_q || stop || last_iter_c) begin
               state_d = FIN;
            end else begin
               state_d = WR_GO;
            end
         end
         FIN: begin
            stop_pend_d = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            stop_pend_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and registered outputs, decoded from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         iter_lim_q  <= '0;
         wdog_q      <= '0;
         stop_pend_q <= 1'b0;
         err_q       <= 1'b0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         finished_q  <= 1'b0;
         wr_start_q  <= 1'b0;
         rd_start_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         iter_lim_q  <= iter_lim_d;
         wdog_q      <= wdog_d;
         stop_pend_q <= stop_pend_d;
         err_q       <= err_d;
         timeout_q   <= timeout_d;
         busy_q      <= (state_d != IDLE);
         finished_q  <= (state_d == FIN);
         wr_start_q  <= (state_d == WR_GO);
         rd_start_q  <= (state_d == RD_GO);
      end
   end

   sat_counter #(.W(ITER_WIDTH)) u_pass_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .inc_i   (pass_inc),
      .count_o (pass_count)
   );

   sat_counter #(.W(ITER_WIDTH)) u_fail_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .inc_i   (fail_inc),
      .count_o (fail_count)
   );

   sat_counter #(.W(ITER_WIDTH)) u_iter_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .inc_i   (iter_inc),
      .count_o (iter_cnt)
   );

   assign busy     = busy_q;
   assign finished = finished_q;
   assign timeout  = timeout_q;
   assign wr_start = wr_start_q;
   assign rd_start = rd_start_q;

endmodule

// File: tb/tb_axi4_test_sequencer.sv
// Scoreboard bench for axi4_test_sequencer: a main instance (16-cycle
// watchdog, read phase on) and a write-only instance, each with engine models.
module tb_axi4_test_sequencer;

   localparam int unsigned IW      = 16;
   localparam int          ENG_LAT = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          run, stop;
   logic [IW-1:0] iterations;
   logic          busy, finished, timeout;
   logic [IW-1:0] pass_count, fail_count;
   logic          wr_start, wr_done, wr_error;
   logic          rd_start, rd_done, rd_error;

   logic          run_wo, stop_wo;
   logic          busy_wo, finished_wo, timeout_wo;
   logic [IW-1:0] pass_wo, fail_wo;
   logic          wr_start_wo, wr_done_wo, wr_error_wo;
   logic          rd_start_wo, rd_done_wo, rd_error_wo;

   always #5 clk = ~clk;

   axi4_test_sequencer #(.ITER_WIDTH(IW), .TMO_WIDTH(20), .TMO_CYCLES(16), .RD_ENABLE(1'b1)) dut (
      .clk(clk), .reset(reset), .run(run), .stop(stop), .iterations(iterations),
      .busy(busy), .finished(finished), .timeout(timeout),
      .pass_count(pass_count), .fail_count(fail_count),
      .wr_start(wr_start), .wr_done(wr_done), .wr_error(wr_error),
      .rd_start(rd_start), .rd_done(rd_done), .rd_error(rd_error)
   );

   axi4_test_sequencer #(.ITER_WIDTH(IW), .TMO_WIDTH(20), .TMO_CYCLES(64), .RD_ENABLE(1'b0)) dut_wo (
      .clk(clk), .reset(reset), .run(run_wo), .stop(stop_wo), .iterations(iterations),
      .busy(busy_wo), .finished(finished_wo), .timeout(timeout_wo),
      .pass_count(pass_wo), .fail_count(fail_wo),
      .wr_start(wr_start_wo), .wr_done(wr_done_wo), .wr_error(wr_error_wo),
      .rd_start(rd_start_wo), .rd_done(rd_done_wo), .rd_error(rd_error_wo)
   );

   typedef struct {
      int pass; int fail; int tmo; int nwr; int nrd; int gap;
   } exp_t;

   exp_t sb_q[$];
   exp_t sbw_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic exp_t mk(input int p, input int f, input int t, input int w, input int r, input int g);
      exp_t e;
      e.pass = p; e.fail = f; e.tmo = t; e.nwr = w; e.nrd = r; e.gap = g;
      return e;
   endfunction

   // Engine models: done ENG_LAT-ish cycles after start; written only here
   bit wr_hang     = 1'b0;
   int rd_err_iter = 0;
   int rd_num      = 0;
   int wr_cd = 0, rd_cd = 0;
   initial begin
      wr_done = 1'b0; wr_error = 1'b0; rd_done = 1'b0; rd_error = 1'b0;
      forever begin
         @(posedge clk); #1;
         wr_done = 1'b0; wr_error = 1'b0; rd_done = 1'b0; rd_error = 1'b0;
         if (reset) begin
            wr_cd = 0; rd_cd = 0;
         end else begin
            if (wr_cd == 1) wr_done = 1'b1;
            if (wr_cd != 0) wr_cd--;
            if (wr_start && !wr_hang) wr_cd = ENG_LAT;
            if (rd_cd == 1) begin
               rd_done  = 1'b1;
               rd_error = (rd_num == rd_err_iter);
            end
            if (rd_cd != 0) rd_cd--;
            if (rd_start) begin
               rd_num++;
               rd_cd = ENG_LAT;
            end
         end
      end
   end

   int inject_req = 0;
   int inject_seen = 0;
   int wrw_cd = 0;
   initial begin
      wr_done_wo = 1'b0; wr_error_wo = 1'b0; rd_done_wo = 1'b0; rd_error_wo = 1'b0;
      forever begin
         @(posedge clk); #1;
         wr_done_wo = 1'b0;
         if (reset) begin
            wrw_cd = 0;
         end else begin
            if (inject_req != inject_seen) begin
               wr_done_wo  = 1'b1;
               inject_seen = inject_req;
            end
            if (wrw_cd == 1) wr_done_wo = 1'b1;
            if (wrw_cd != 0) wrw_cd--;
            if (wr_start_wo) wrw_cd = ENG_LAT;
         end
      end
   end

   // Monitor for the main instance: pops on every finished pulse
   int mon_wr = 0, mon_rd = 0, mon_cyc = 0, last_wr_cyc = 0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      mon_cyc++;
      if (reset) begin
         mon_wr = 0; mon_rd = 0;
      end else begin
         if (wr_start) begin mon_wr++; last_wr_cyc = mon_cyc; end
         if (rd_start) mon_rd++;
         if (finished) begin
            check("sb_entry_available", longint'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("pass_count", pass_count, e.pass);
               check("fail_count", fail_count, e.fail);
               check("timeout", timeout, e.tmo);
               check("wr_start_pulses", mon_wr, e.nwr);
               check("rd_start_pulses", mon_rd, e.nrd);
               if (e.gap != 0) check("wr_start_to_finished", mon_cyc - last_wr_cyc, e.gap);
            end
            mon_wr = 0; mon_rd = 0;
         end
      end
   end

   // Monitor for the write-only instance
   int monw_wr = 0, monw_rd = 0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
         monw_wr = 0; monw_rd = 0;
      end else begin
         if (wr_start_wo) monw_wr++;
         if (rd_start_wo) monw_rd++;
         if (finished_wo) begin
            check("wo_sb_entry_available", longint'(sbw_q.size() > 0), 1);
            if (sbw_q.size() > 0) begin
               e = sbw_q.pop_front();
               check("wo_pass_count", pass_wo, e.pass);
               check("wo_fail_count", fail_wo, e.fail);
               check("wo_timeout", timeout_wo, e.tmo);
               check("wo_wr_start_pulses", monw_wr, e.nwr);
               check("wo_rd_start_pulses", monw_rd, e.nrd);
            end
            monw_wr = 0; monw_rd = 0;
         end
      end
   end

   task automatic pulse_run(input logic [IW-1:0] n);
      @(negedge clk);
      iterations = n;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_idle(input bit sel_wo, input int budget, input string name);
      int k = 0;
      while ((sel_wo ? busy_wo : busy) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      check(name, longint'(sel_wo ? busy_wo : busy), 0);
   endtask

   task automatic wait_rd_num(input int target, input int budget);
      int k = 0;
      while ((rd_num < target) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      check("reached_read_phase", longint'(rd_num >= target), 1);
   endtask

   initial begin
      int base;
      reset = 1'b1; run = 1'b0; stop = 1'b0; run_wo = 1'b0; stop_wo = 1'b0;
      iterations = '0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_pass", pass_count, 0);
      check("rst_fail", fail_count, 0);
      check("rst_timeout", timeout, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: three clean iterations; start latency one cycle after run
      sb_q.push_back(mk(3, 0, 0, 3, 3, 0));
      pulse_run(16'd3);
      check("run_to_wr_start", wr_start, 1);
      check("busy_after_run", busy, 1);
      wait_idle(1'b0, 400, "t1_idle");

      // 2: read error on iteration 2 of 4
      rd_err_iter = rd_num + 2;
      sb_q.push_back(mk(3, 1, 0, 4, 4, 0));
      pulse_run(16'd4);
      wait_idle(1'b0, 500, "t2_idle");
      rd_err_iter = 0;

      // 3: endless run, stop during RD_WAIT of iteration 5
      base = rd_num;
      sb_q.push_back(mk(5, 0, 0, 5, 5, 0));
      pulse_run(16'd0);
      wait_rd_num(base + 5, 800);
      repeat (3) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_idle(1'b0, 200, "t3_idle");

      // 4: write engine hangs; 16 WR_WAIT cycles then FIN
      wr_hang = 1'b1;
      sb_q.push_back(mk(0, 1, 1, 1, 0, 17));
      pulse_run(16'd2);
      wait_idle(1'b0, 100, "t4_idle");
      repeat (3) @(negedge clk);
      check("timeout_sticky_idle", timeout, 1);
      check("fail_hold_idle", fail_count, 1);
      wr_hang = 1'b0;

      // 5: async reset in RD_WAIT of iteration 2, then ignored run while busy
      base = rd_num;
      pulse_run(16'd3);
      wait_rd_num(base + 2, 200);
      repeat (3) @(negedge clk);
      check("pre_reset_pass", pass_count, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_pass", pass_count, 0);
      check("async_rst_rd_start", rd_start, 0);
      check("async_rst_timeout", timeout, 0);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      sb_q.push_back(mk(2, 0, 0, 2, 2, 0));
      pulse_run(16'd2);
      repeat (3) @(negedge clk);
      iterations = 16'd5;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      check("run_while_busy_busy", busy, 1);
      check("run_while_busy_pass", pass_count, 0);
      wait_idle(1'b0, 300, "t5_idle");

      // 6: write-only instance, two iterations, then a stray done in IDLE
      sbw_q.push_back(mk(2, 0, 0, 2, 0, 0));
      @(negedge clk);
      iterations = 16'd2;
      run_wo = 1'b1;
      @(negedge clk);
      run_wo = 1'b0;
      wait_idle(1'b1, 200, "t6_idle");
      inject_req++;
      repeat (4) @(negedge clk);
      check("wo_stray_done_busy", busy_wo, 0);
      check("wo_stray_done_pass", pass_wo, 2);
      check("wo_stray_done_wr_start", monw_wr, 0);

      repeat (3) @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      check("sbw_drained", sbw_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
